// File: rtl/pipe_regfile_pkg.sv
// pipe_regfile_pkg: shared FSM state type and default geometry for the pipelined register file.
package pipe_regfile_pkg;
  typedef enum logic {CLEAR, READY} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/pipe_regfile_clear_seq.sv
// pipe_regfile_clear_seq: CLEAR/READY sequencer that sweeps every entry to zero after reset or Clear_req.
module pipe_regfile_clear_seq
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear_req,
  output logic              Ready,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? READY : CLEAR;
    end else if (Clear_req) begin
      cnt_d = '0;
      state_d = CLEAR;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign Ready = state_q == READY;
  assign clear_we = state_q == CLEAR;
  assign clear_addr = cnt_q;
endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: byte-masked 2R1W register file with a sequenced clear and optional entry-0 hardwiring.
// Optional same-cycle write-to-read forwarding is enabled by defining PIPE_REGFILE_BYPASS_EN.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   Read_register_1,
  input  logic [ADDR_W-1:0]   Read_register_2,
  output logic [DATA_W-1:0]   Read_data_1,
  output logic [DATA_W-1:0]   Read_data_2,
  input  logic [ADDR_W-1:0]   Write_register,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_mask,
  input  logic                RegWrite,
  input  logic                Clear_req,
  output logic                Ready
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] bit_mask, wr_d;
  logic [ADDR_W-1:0] clear_addr;
  logic clear_we, wr_en, zero0, byp1, byp2;
  pipe_regfile_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
    .Clock(Clock),
    .Reset(Reset),
    .Clear_req(Clear_req),
    .Ready(Ready),
    .clear_we(clear_we),
    .clear_addr(clear_addr)
  );
  for (genvar m = 0; m < DATA_W/8; m++) begin : g_mask
    assign bit_mask[m*8 +: 8] = {8{Write_mask[m]}};
  end
  assign zero0 = ZERO_REG != 0;
  // A write is lost if the same edge resets or starts a clear.
  assign wr_en = Ready & RegWrite & ~Reset & ~Clear_req & ~(zero0 && Write_register == '0);
  assign wr_d = (Write_data & bit_mask) | (mem_q[Write_register] & ~bit_mask);
  always_ff @(posedge Clock) begin
    if (clear_we)
      mem_q[clear_addr] <= '0;
    else if (wr_en)
      mem_q[Write_register] <= wr_d;
  end
`ifdef PIPE_REGFILE_BYPASS_EN
  assign byp1 = wr_en && Read_register_1 == Write_register;
  assign byp2 = wr_en && Read_register_2 == Write_register;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign Read_data_1 = (!Ready || (zero0 && Read_register_1 == '0)) ? '0 : byp1 ? wr_d : mem_q[Read_register_1];
  assign Read_data_2 = (!Ready || (zero0 && Read_register_2 == '0)) ? '0 : byp2 ? wr_d : mem_q[Read_register_2];
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed scoreboard bench for pipe_regfile with immediate-assertion checks.
module tb_pipe_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] rd1, rd2, wd = '0;
  logic [3:0]  wm = '0;
  logic        we = 1'b0, clr = 1'b0, rdy;
  logic [31:0] sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_regfile dut (
    .Clock(clk),
    .Reset(rst),
    .Read_register_1(ra1),
    .Read_register_2(ra2),
    .Read_data_1(rd1),
    .Read_data_2(rd2),
    .Write_register(wa),
    .Write_data(wd),
    .Write_mask(wm),
    .RegWrite(we),
    .Clear_req(clr),
    .Ready(rdy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask
  task automatic wait_ready(input string tag, input bit pulse_clr);
    int n = 0;
    while (!rdy && n < 100) begin
      clr = pulse_clr && n == 5;
      n++;
      step();
    end
    clr = 1'b0;
    push(32);
    check(tag, 32'(n));
  endtask
  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    wa = a; wd = d; wm = m; we = 1'b1;
    step();
    we = 1'b0;
  endtask
  initial begin
    step();
    rst = 1'b0;
    ra1 = 5'd3; ra2 = 5'd3;
    #1;
    push(0); check("reset_ready", 32'(rdy));
    push(0); check("reset_rd1", rd1);
    push(0); check("reset_rd2", rd2);
    wa = 5'd3; wd = 32'hDEADBEEF; wm = 4'hF; we = 1'b1;
    wait_ready("clear_len_after_reset", 1'b0);
    we = 1'b0;
    #1;
    push(0); check("r3_write_ignored", rd1);
    write(5'd5, 32'h11223344, 4'b1111);
    write(5'd5, 32'hAABBCCDD, 4'b0101);
    ra1 = 5'd5; #1;
    push(32'h11BB33DD); check("r5_byte_mask", rd1);
    wa = 5'd0; wd = 32'h12345678; wm = 4'hF; we = 1'b1; ra1 = 5'd0; ra2 = 5'd0; #1;
    push(0); check("r0_same_cycle_rd1", rd1);
    step(); we = 1'b0; #1;
    push(0); check("r0_rd1", rd1);
    push(0); check("r0_rd2", rd2);
    write(5'd7, 32'h01020304, 4'hF);
    wa = 5'd7; wd = 32'hCAFEF00D; wm = 4'hF; we = 1'b1; ra1 = 5'd7; ra2 = 5'd7; #1;
`ifdef PIPE_REGFILE_BYPASS_EN
    push(32'hCAFEF00D);
`else
    push(32'h01020304);
`endif
    check("r7_same_cycle", rd1);
    step(); we = 1'b0; #1;
    push(32'hCAFEF00D); check("r7_after_rd1", rd1);
    push(32'hCAFEF00D); check("r7_after_rd2", rd2);
    write(5'd12, 32'h0BADF00D, 4'hF);
    wa = 5'd9; wd = 32'h55555555; wm = 4'hF; we = 1'b1; clr = 1'b1;
    step();
    we = 1'b0; clr = 1'b0; ra1 = 5'd12; ra2 = 5'd9; #1;
    push(0); check("clear_ready_low", 32'(rdy));
    push(0); check("clear_rd_zero", rd1);
    wait_ready("clear_len_clr_ignored", 1'b1);
    push(0); check("r9_write_dropped", rd2);
    push(0); check("r12_cleared", rd1);
    write(5'd12, 32'h87654321, 4'hF);
    write(5'd30, 32'hFFFFFFFF, 4'hF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (9) step();
    rst = 1'b1; we = 1'b1; wa = 5'd30; wd = 32'h13579BDF;
    step();
    rst = 1'b0; we = 1'b0;
    wait_ready("clear_len_after_midreset", 1'b0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); #1;
      push(0); check($sformatf("all_zero_rd1_%0d", i), rd1);
      push(0); check($sformatf("all_zero_rd2_%0d", 31 - i), rd2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
